median_stream: RTL
==================

// Module: median_stream
// PURPOSE
// - Downstream consumer of the pixel delay line: collects a window of N serial samples, then
//   computes their median by repeated max-extraction over an internal rotating register chain.
// - Sits between the delay-line output and the filtered-pixel writer.
// - Processes one window at a time; does not accept input while computing.
// PARAMETERS
// - DATA_W  8  sample width; unsigned
// - N       9  window size; must be odd and >= 3
// PORTS
// - clk         in   1       single clock; all state updates on its rising edge
// - rst         in   1       asynchronous, active-high reset
// - din_valid   in   1       din carries a sample this cycle
// - din         in   DATA_W  input sample (delay-line output)
// - ready       out  1       high = block accepts samples; a sample transfers when din_valid && ready
// - dout        out  DATA_W  median of the last completed window; held until the next result
// - dout_valid  out  1       one-cycle pulse: dout updated this cycle
// BEHAVIOUR
// - Reset (async, any time): state=LOAD, sample count=0, chain=0, MAX=0, dout=0, dout_valid=0,
//   ready=1 as soon as rst is released. A reset mid-LOAD or mid-COMPUTE aborts the window with no output.
// - Datapath: chain R[0..N-1] (R[0]=head, R[N-1]=tail) plus one MAX register.
// - LOAD (ready=1)
//   - On each transfer: R[0]<=din, R[i+1]<=R[i], count++.
//   - Gaps (din_valid=0) hold all state.
//   - On the Nth transfer: -> COMPUTE, pass=0, cyc=0, MAX=0.
// - COMPUTE (ready=0; din/din_valid ignored): each cycle the tail is compared with MAX.
//   - If R[N-1] > MAX (strict): MAX<=R[N-1], R[0]<=MAX (old MAX).
//   - Else: R[0]<=R[N-1], MAX unchanged.
//   - R[i+1]<=R[i] always; cyc++.
//   - Each pass is exactly N cycles and removes one instance of the current max. A 0 re-enters the
//     chain; 0 is <= every value, so the order is unaffected.
//   - End of pass (cyc==N-1):
//     - If pass < (N-1)/2: pass++, cyc=0, MAX<=0.
//     - Else (final pass, pass==(N-1)/2): the next MAX value is the median.
//       Next edge: dout<=final MAX, dout_valid<=1, state -> LOAD, count=0.
// - Timing: dout_valid rises on the cycle after the last COMPUTE cycle. ready=1 in that same cycle,
//   so back-to-back windows are allowed.
// - Latency: the Nth accepted sample is followed by ((N+1)/2)*N COMPUTE cycles, then dout_valid.
//   N=9: 45 cycles.
// - Ties and duplicates: the strict > rule removes exactly one copy per pass; duplicate maxima
//   survive to later passes.
// - Width rules
//   - Compare is unsigned DATA_W.
//   - count and cyc are $clog2(N+1) bits.
//   - pass is $clog2((N+1)/2+1) bits.
//   - No arithmetic on data, so no overflow is possible.
// - dout_valid is never high in two consecutive cycles. dout keeps its value while in LOAD.
// STRUCTURE
// - median_pkg holds:
//   - typedef enum logic {LOAD, COMPUTE} med_state_t;
//   - localparams DATA_W_DEF=8, N_DEF=9, and function passes(n)=(n+1)/2.
// - One sub-module, median_cmp_swap: combinational; inputs tail and max; outputs new_max and to_head.
// - The FSM, the counters and the chain stay in median_stream (single always_ff with async rst).
// TESTING
// - Load 1..9 with din_valid every cycle -> ready=0 for 45 cycles, then dout=5 with a single
//   dout_valid pulse.
// - Load 9,8,...,1 with random one-cycle din_valid gaps -> dout=5, same 45-cycle latency counted
//   from the 9th transfer.
// - Load all 7s -> dout=7. Load {0,0,0,0,255,255,255,255,3} -> dout=3.
// - Load {255 x5, 0 x4} -> dout=255. Load {0 x5, 255 x4} -> dout=0 (duplicate/extreme handling).
// - Assert rst 20 cycles into COMPUTE -> dout=0, dout_valid=0, ready=1 right after release.
//   A new window 10..90 step 10 -> dout=50.
// - Two windows back-to-back: second window's first sample presented on the dout_valid cycle is
//   accepted. Outputs 5, then 50, each exactly 45 cycles after its last sample.

Source files
------------

// File: rtl/median_pkg.sv
// Shared types, defaults and helpers for the streaming median filter.
package median_pkg;

  typedef enum logic {LOAD, COMPUTE} med_state_t;

  localparam int DATA_W_DEF = 8;
  localparam int N_DEF      = 9;

  // Number of max-extraction passes needed to reach the median of n samples.
  function automatic int passes(input int n);
    return (n + 1) / 2;
  endfunction

endpackage

// File: rtl/median_cmp_swap.sv
// Compare the chain tail with the running maximum; the larger value stays in MAX
// and the smaller one is recirculated to the head of the chain.
module median_cmp_swap #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] tail,
  input  logic [DATA_W-1:0] max,
  output logic [DATA_W-1:0] new_max,
  output logic [DATA_W-1:0] to_head
);

  logic take_tail;

  // Strict compare: on a tie the tail recirculates, so exactly one copy is removed per pass.
  assign take_tail = tail > max;
  assign new_max   = take_tail ? tail : max;
  assign to_head   = take_tail ? max  : tail;

endmodule

// File: rtl/median_stream.sv
// Collects a window of N serial samples and finds their median by repeated
// max-extraction over a rotating register chain.
module median_stream
  import median_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int N      = N_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              din_valid,
  input  logic [DATA_W-1:0] din,
  output logic              ready,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid
);

  localparam int CNT_W     = $clog2(N + 1);
  localparam int PASS_W    = $clog2(passes(N) + 1);
  localparam int LAST_PASS = (N - 1) / 2;

  med_state_t        state, state_next;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  cyc;
  logic [PASS_W-1:0] pass;
  logic [DATA_W-1:0] chain [N];
  logic [DATA_W-1:0] max_q;

  logic              take;
  logic              last_sample;
  logic              last_cyc;
  logic              final_pass;
  logic [DATA_W-1:0] new_max;
  logic [DATA_W-1:0] to_head;

  median_cmp_swap #(.DATA_W(DATA_W)) u_cmp_swap (
    .tail    (chain[N-1]),
    .max     (max_q),
    .new_max (new_max),
    .to_head (to_head)
  );

  assign ready = (state == LOAD);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_next  = state;
    take        = (state == LOAD) && din_valid;
    last_sample = (count == CNT_W'(N - 1));
    last_cyc    = (cyc == CNT_W'(N - 1));
    final_pass  = (pass == PASS_W'(LAST_PASS));
    case (state)
      LOAD:    if (take && last_sample)     state_next = COMPUTE;
      COMPUTE: if (last_cyc && final_pass)  state_next = LOAD;
    endcase
  end

  // NOTE: registers use non-blocking assignments so every update sees pre-edge values;
  // the chain is plain flops, not a RAM, so resetting it to zero is cheap and intended.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= LOAD;
      count      <= '0;
      cyc        <= '0;
      pass       <= '0;
      max_q      <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      for (int i = 0; i < N; i++) chain[i] <= '0;
    end else begin
      state      <= state_next;
      dout_valid <= 1'b0;
      case (state)
        LOAD: begin
          if (take) begin
            chain[0] <= din;
            for (int i = 0; i < N - 1; i++) chain[i+1] <= chain[i];
            if (last_sample) begin
              count <= '0;
              cyc   <= '0;
              pass  <= '0;
              max_q <= '0;
            end else begin
              count <= count + CNT_W'(1);
            end
          end
        end
        COMPUTE: begin
          chain[0] <= to_head;
          for (int i = 0; i < N - 1; i++) chain[i+1] <= chain[i];
          if (!last_cyc) begin
            cyc   <= cyc + CNT_W'(1);
            max_q <= new_max;
          end else if (!final_pass) begin
            // A fresh MAX of 0 starts the next pass; the extracted maximum is discarded.
            cyc   <= '0;
            pass  <= pass + PASS_W'(1);
            max_q <= '0;
          end else begin
            max_q      <= new_max;
            dout       <= new_max;
            dout_valid <= 1'b1;
            count      <= '0;
          end
        end
      endcase
    end
  end

endmodule
